// File: rtl/datamem_hs.sv
// RV32 load/store unit with a valid/ready request handshake and programmable wait states,
// fronting a word-organised RAM with byte-lane write enables (byte-addressed, little-endian).
module datamem_hs #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    state_t      state_q;
    logic [3:0]  waitCnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [2:0]  func3_q;
    logic [31:0] wdata_q;

    logic        reqReady_q;
    logic        rspValid_q;
    logic [31:0] rspData_q;
    logic        rspErr_q;

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        lane;
    logic              outOfRange;
    logic              misaligned;
    logic              badFunc;
    logic              accessErr;
    logic [3:0]        byteEn;
    logic [31:0]       wrData;
    logic [31:0]       ramWord;
    logic [7:0]        rdByte;
    logic [15:0]       rdHalf;
    logic [31:0]       loadData;
    logic              ramWrite;
    logic [31:0]       rspData_d;

    // Decode of the captured request; only meaningful while the FSM sits in RESP.
    always_comb begin
        wordIdx    = addr_q[ADDR_W+1:2];
        lane       = addr_q[1:0];
        outOfRange = |addr_q[31:ADDR_W+2];

        case (func3_q[1:0])
            2'd1:    misaligned = addr_q[0];
            2'd2:    misaligned = (lane != 2'd0);
            default: misaligned = 1'b0;
        endcase

        if (we_q) begin
            badFunc = func3_q[2] || (func3_q[1:0] == 2'd3);
        end else begin
            badFunc = (func3_q == 3'd3) || (func3_q[2:1] == 2'b11);
        end

        accessErr = outOfRange || misaligned || badFunc;
    end

    // Store lane selection: narrow stores replicate their data so any lane can pick it up.
    always_comb begin
        byteEn = 4'b0000;
        wrData = wdata_q;
        case (func3_q[1:0])
            2'd0: begin
                byteEn = 4'b0001 << lane;
                wrData = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                byteEn = lane[1] ? 4'b1100 : 4'b0011;
                wrData = {2{wdata_q[15:0]}};
            end
            2'd2: begin
                byteEn = 4'b1111;
                wrData = wdata_q;
            end
            default: begin
                byteEn = 4'b0000;
                wrData = wdata_q;
            end
        endcase
    end

    always_comb begin
        ramWord = mem[wordIdx];

        case (lane)
            2'd0:    rdByte = ramWord[7:0];
            2'd1:    rdByte = ramWord[15:8];
            2'd2:    rdByte = ramWord[23:16];
            default: rdByte = ramWord[31:24];
        endcase
        rdHalf = lane[1] ? ramWord[31:16] : ramWord[15:0];

        case (func3_q)
            3'd0:    loadData = {{24{rdByte[7]}}, rdByte};
            3'd1:    loadData = {{16{rdHalf[15]}}, rdHalf};
            3'd2:    loadData = ramWord;
            3'd4:    loadData = {24'd0, rdByte};
            3'd5:    loadData = {16'd0, rdHalf};
            default: loadData = 32'd0;
        endcase

        rspData_d = (accessErr || we_q) ? 32'd0 : loadData;
        ramWrite  = (state_q == RESP) && we_q && !accessErr;
    end

    // RAM has no reset; an async reset drops state_q out of RESP, which blocks the write.
    always_ff @(posedge clk) begin
        if (ramWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wrData[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            waitCnt_q  <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            func3_q    <= 3'd0;
            wdata_q    <= 32'd0;
            reqReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspData_q  <= 32'd0;
            rspErr_q   <= 1'b0;
        end else begin
            rspValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        addr_q     <= req_addr;
                        func3_q    <= req_func3;
                        wdata_q    <= req_wdata;
                        reqReady_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q   <= WAIT;
                            waitCnt_q <= LAT;
                        end
                    end
                end
                WAIT: begin
                    waitCnt_q <= waitCnt_q - 4'd1;
                    if (waitCnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    reqReady_q <= 1'b1;
                    rspValid_q <= 1'b1;
                    rspData_q  <= rspData_d;
                    rspErr_q   <= accessErr;
                end
                default: begin
                    state_q    <= IDLE;
                    reqReady_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = reqReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspData_q;
    assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_datamem_hs.sv
// Directed self-checking bench for datamem_hs: one LATENCY=2 instance for the
// load/store/error/reset sequence and one LATENCY=0 instance for back-to-back handshakes.
module tb_datamem_hs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWe = 1'b0;
    logic [31:0] reqAddr = 32'd0;
    logic [2:0]  reqFunc3 = 3'd0;
    logic [31:0] reqWdata = 32'd0;
    logic        rspValid;
    logic [31:0] rspRdata;
    logic        rspErr;

    logic        bValid = 1'b0;
    logic        bReady;
    logic        bWe = 1'b0;
    logic [31:0] bAddr = 32'd0;
    logic [2:0]  bFunc3 = 3'd0;
    logic [31:0] bWdata = 32'd0;
    logic        bRspValid;
    logic [31:0] bRdata;
    logic        bErr;

    int checks = 0;
    int failures = 0;
    int bCount = 0;

    always #5 clk = ~clk;

    datamem_hs #(.ADDR_W(10), .LATENCY(2)) dutA (
        .clk       (clk),
        .reset     (reset),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .req_we    (reqWe),
        .req_addr  (reqAddr),
        .req_func3 (reqFunc3),
        .req_wdata (reqWdata),
        .rsp_valid (rspValid),
        .rsp_rdata (rspRdata),
        .rsp_err   (rspErr)
    );

    datamem_hs #(.ADDR_W(10), .LATENCY(0)) dutB (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bValid),
        .req_ready (bReady),
        .req_we    (bWe),
        .req_addr  (bAddr),
        .req_func3 (bFunc3),
        .req_wdata (bWdata),
        .rsp_valid (bRspValid),
        .rsp_rdata (bRdata),
        .rsp_err   (bErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One request on dutA; inputs are scrambled right after accept to show they are ignored.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                                 input logic [2:0] f3, input logic [31:0] wd,
                                 input logic [31:0] expData, input logic expErr);
        int readyWait = 0;
        int lat = 0;
        @(negedge clk);
        reqWe    = we;
        reqAddr  = addr;
        reqFunc3 = f3;
        reqWdata = wd;
        reqValid = 1'b1;
        while (!reqReady && readyWait < 20) begin
            @(negedge clk);
            readyWait++;
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqWe    = ~we;
        reqAddr  = 32'hFFFF_FFFF;
        reqFunc3 = 3'd7;
        reqWdata = 32'h0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (rspValid) break;
        end
        checkOutput({tag, " latency"}, lat, 32'd3);
        checkOutput({tag, " rdata"}, rspRdata, expData);
        checkOutput({tag, " err"}, {31'd0, rspErr}, {31'd0, expErr});
    endtask

    initial begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset ready", {31'd0, reqReady}, 32'd1);
        checkOutput("reset valid", {31'd0, rspValid}, 32'd0);
        checkOutput("reset rdata", rspRdata, 32'd0);
        checkOutput("reset err", {31'd0, rspErr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus("SW 0x10", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0);
        applyStimulus("LW 0x10", 1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);

        applyStimulus("SB 0x13", 1'b1, 32'h13, 3'd0, 32'h00000080, 32'h0, 1'b0);
        applyStimulus("LB 0x13", 1'b0, 32'h13, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0);
        applyStimulus("LBU 0x13", 1'b0, 32'h13, 3'd4, 32'h0, 32'h00000080, 1'b0);
        applyStimulus("LW 0x10 after SB", 1'b0, 32'h10, 3'd2, 32'h0, 32'h80ADBEEF, 1'b0);

        applyStimulus("SH 0x12", 1'b1, 32'h12, 3'd1, 32'h1234ABCD, 32'h0, 1'b0);
        applyStimulus("LH 0x12", 1'b0, 32'h12, 3'd1, 32'h0, 32'hFFFFABCD, 1'b0);
        applyStimulus("LHU 0x12", 1'b0, 32'h12, 3'd5, 32'h0, 32'h0000ABCD, 1'b0);
        applyStimulus("LW 0x10 after SH", 1'b0, 32'h10, 3'd2, 32'h0, 32'hABCDBEEF, 1'b0);

        applyStimulus("LW 0x12 misaligned", 1'b0, 32'h12, 3'd2, 32'h0, 32'h0, 1'b1);
        applyStimulus("LH 0x11 misaligned", 1'b0, 32'h11, 3'd1, 32'h0, 32'h0, 1'b1);

        applyStimulus("SW 0x0", 1'b1, 32'h0, 3'd2, 32'h11223344, 32'h0, 1'b0);
        applyStimulus("SW 0x1000 range", 1'b1, 32'h1000, 3'd2, 32'hCAFEF00D, 32'h0, 1'b1);
        applyStimulus("LW 0x0 after range", 1'b0, 32'h0, 3'd2, 32'h0, 32'h11223344, 1'b0);
        applyStimulus("load func3 3", 1'b0, 32'h0, 3'd3, 32'h0, 32'h0, 1'b1);
        applyStimulus("store func3 4", 1'b1, 32'h0, 3'd4, 32'hFFFFFFFF, 32'h0, 1'b1);
        applyStimulus("LW 0x0 after bad store", 1'b0, 32'h0, 3'd2, 32'h0, 32'h11223344, 1'b0);

        // Strobe is one cycle wide, but data holds until the next response.
        @(posedge clk);
        #1;
        checkOutput("strobe drops", {31'd0, rspValid}, 32'd0);
        checkOutput("rdata holds", rspRdata, 32'h11223344);

        applyStimulus("SW 0x20 pre", 1'b1, 32'h20, 3'd2, 32'hAABBCCDD, 32'h0, 1'b0);

        // Reset lands while the SW 0x20 is still in its wait states.
        @(negedge clk);
        reqWe    = 1'b1;
        reqAddr  = 32'h20;
        reqFunc3 = 3'd2;
        reqWdata = 32'h55;
        reqValid = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midwait ready", {31'd0, reqReady}, 32'd1);
        checkOutput("midwait rdata", rspRdata, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("midwait valid c%0d", k), {31'd0, rspValid}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("LW 0x20 post reset", 1'b0, 32'h20, 3'd2, 32'h0, 32'hAABBCCDD, 1'b0);

        // Zero-latency instance with req_valid held high: accept, respond, accept, ...
        @(negedge clk);
        bWe    = 1'b1;
        bAddr  = 32'h4;
        bFunc3 = 3'd2;
        bWdata = 32'h01020304;
        bValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("B ready e%0d", k), {31'd0, bReady}, (k % 2 == 1) ? 32'd1 : 32'd0);
            checkOutput($sformatf("B valid e%0d", k), {31'd0, bRspValid}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (bRspValid) bCount++;
        end
        bValid = 1'b0;
        checkOutput("B response count", bCount, 32'd4);
        checkOutput("B store rdata", bRdata, 32'd0);
        checkOutput("B store err", {31'd0, bErr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datamem_hs.md
Name: datamem_hs

Overview:
- Parametrised successor to the single-cycle data memory: RV32 load/store unit with a valid/ready request handshake, configurable wait-state latency, configurable depth and error reporting.
- Sits between the core's memory stage and a word-organised RAM, so the core can stall on memory accesses.
- Byte-addressed, little-endian.
- Supports LB/LH/LW/LBU/LHU and SB/SH/SW, selected by func3.

Parameters:
- ADDR_W, 10, word-address width; depth = 2^ADDR_W 32-bit words.
- LATENCY, 2, wait cycles inserted between request accept and response; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears all control state.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_func3  input  3  RV32 funct3 of the load/store.
- req_wdata  input  32  store data (rs2).
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  request rejected; valid only with rsp_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Wait counter is cleared and any captured request is discarded, with no RAM write.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
  - Accept at edge N when IDLE && req_valid. Capture we, addr, func3 and wdata. Go to WAIT with counter=LATENCY, or straight to RESP if LATENCY=0.
  - WAIT: the counter decrements each cycle; when it reaches 0, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, first visible after edge N+1+LATENCY.
  - The RAM write (store) and the RAM read (load) happen at that same edge.
  - Next state is IDLE. The earliest next accept is edge N+2+LATENCY.
- Requests offered while req_ready=0 are ignored. The core must hold req_valid until accepted. Inputs changing after accept have no effect.
- Address decoding:
  - Word index = addr[ADDR_W+1:2]; byte lane = addr[1:0].
  - Out of range when any of addr[31:ADDR_W+2] is non-zero.
- Error conditions (rsp_err=1, rsp_rdata=0, no write):
  - Out-of-range address.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load func3 in {3,6,7}.
  - Store func3 not in {0,1,2}.
- Loads:
  - func3 0 = LB, sign-extend byte lane.
  - func3 1 = LH, sign-extend halfword at addr[1].
  - func3 2 = LW.
  - func3 4 = LBU, zero-extend.
  - func3 5 = LHU, zero-extend.
- Stores:
  - SB writes only the addressed byte lane with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unwritten lanes keep their contents.
  - Store response has rsp_rdata=0.
- Outputs are registered. rsp_rdata and rsp_err hold their values until the next response or reset; only rsp_valid is a strobe.
- A load to an address in the same request sequence as a preceding store sees the stored data (the store has completed before the next accept).

Test Plan:
- LATENCY=2. SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> each response has rsp_valid high 3 cycles after accept; the load returns 0xDEADBEEF with rsp_err=0.
- After the above, SB addr 0x13 data 0x00000080. Then:
  - LB 0x13 -> 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LW 0x10 -> 0x80ADBEEF.
- SH 0x12 data 0x1234ABCD, then LH 0x12 -> 0xFFFFABCD, LHU 0x12 -> 0x0000ABCD, and LW 0x10 -> 0xABCDBEEF. Then:
  - LW 0x12 -> rsp_err=1, rsp_rdata=0.
  - LH 0x11 -> rsp_err=1.
  - SW to 0x1000 (ADDR_W=10) -> rsp_err=1, and a later LW 0x0 is unchanged.
- Hold req_valid high continuously with LATENCY=0 -> accepts every 2nd cycle; req_ready=0 in the RESP cycle; exactly one rsp_valid per accept.
- Assert reset=0 mid-WAIT of SW 0x20 data 0x55 -> rsp_valid stays 0, req_ready=1 immediately, and a following LW 0x20 returns the pre-reset contents.
